sqrt_fixed: RTL and testbench
=============================

Name: sqrt_fixed

Overview:
Parametrised unsigned fixed-point square-root unit, the successor to the integer-only root block.
- Radicand and root are in the same Q format: WIDTH bits total, FBITS of them fractional.
- Uses a two-bits-per-cycle restoring digit recurrence, one root bit per cycle.
- Start/busy/valid handshake with held results; sits beside the divider in the arithmetic datapath.

Parameters:
- WIDTH, 16, total radicand width in bits. Must be ≥ 4.
- FBITS, 8, fractional bits of the radicand and of the root. Constraints: 0 ≤ FBITS < WIDTH, and WIDTH+FBITS even.
- Derived localparam ITER = (WIDTH+FBITS)/2: iteration count and significant root width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset: asynchronous assert, active-low
- start  in  1  request; sampled on posedge, accepted only when busy=0
- rad  in  WIDTH  unsigned radicand, Q(WIDTH-FBITS).FBITS; sampled with an accepted start
- busy  out  1  iteration in progress
- valid  out  1  root/rem hold the result of the last accepted start
- root  out  WIDTH  unsigned root, same Q format; bits above ITER-1 are always 0
- rem  out  WIDTH  remainder (rad<<FBITS) - root_trunc²; ≤ 2·root_trunc, fits ITER+1 bits, zero-extended

Behaviour:
- Reset (rst_n=0, asynchronous): busy=0, valid=0, root=0, rem=0, all internal state cleared.
  - Reset asserted mid-operation aborts the computation; no result is produced.
- Function: root_trunc = floor(sqrt(rad·2^FBITS)) computed on an extended radicand of WIDTH+FBITS bits (rad, then FBITS zeros).
- States: IDLE, CALC, DONE.
  - DONE differs from IDLE only in that valid=1; both accept start.
- Accept: posedge with start=1 and busy=0.
  - Capture rad, clear the accumulator and quotient, clear valid, set busy, go to CALC.
  - Iteration counter is $clog2(ITER+1) bits, starting at 0.
- Start while busy=1 is ignored: no restart, and the captured rad is unaffected.
- CALC, per cycle:
  - Shift the top two bits of the extended radicand into the accumulator (ITER+2 bits wide).
  - Compute test = acc - {q,2'b01}.
  - If test ≥ 0 (MSB clear): acc=test and q={q,1}. Otherwise acc is unchanged and q={q,0}.
- Latency: at the end of the ITER-th CALC cycle, go to DONE.
  - root and rem are registered, busy=0, valid=1, all in the same edge.
  - So busy is high for exactly ITER cycles; valid rises ITER cycles after the accept edge.
- Zero fast path: an accepted start with rad==0 skips CALC.
  - On the next edge: busy=0, valid=1, root=0, rem=0. busy stays 0 throughout.
- Results (root, rem, valid) hold until the next accepted start or reset. They are not cleared by de-asserting start.
- Back-to-back: start held high in DONE is accepted on that edge; valid drops to 0 the next cycle.
- Boundary values:
  - rad = all-ones gives the maximum root 2^ITER - 1 with no overflow.
  - FBITS=0 degenerates to an integer root with ITER=WIDTH/2.

Optional Feature:
- Macro: SQRT_FIXED_ROUND_EN.
- Defined: after the final iteration, if rem_trunc > root_trunc then root = root_trunc+1 (round to nearest; a tie is impossible), else root = root_trunc.
  - rem still reports the truncated remainder.
  - The root register is ITER+1 bits internally so that the carry out of all-ones is kept. Example: root 2^ITER appears at bit ITER of the root port (requires ITER < WIDTH).
  - Latency is unchanged: the compare is done in the DONE-transition cycle.
- Undefined: root = root_trunc; no compare or increment logic is built.

Test Plan:
- Defaults (16/8), rad=16'h0200 (2.0) → root=16'h016A, rem=28; busy high exactly 12 cycles; valid rises with busy falling. Same result with ROUND_EN (28 ≤ 362).
- rad=16'h1000 (16.0) → root=16'h0400, rem=0; rad=16'h0100 (1.0) → root=16'h0100, rem=0.
- rad=16'hFFFF → root=16'h0FFF, rem=7935. With SQRT_FIXED_ROUND_EN: root=16'h1000, rem=7935.
- rad=0 → valid one cycle after accept, busy never asserted, root=0, rem=0. Then start with rad=16'h0400 → root=16'h0200.
- Start pulsed again at CALC cycle 5 with a different rad → ignored; result matches the first rad. Then start held across DONE → second operation accepted, valid drops next cycle.
- rst_n low at CALC cycle 6 → busy, valid, root and rem = 0 immediately (asynchronous). After release, a new start computes correctly.

Source files
------------

// File: rtl/sqrt_fixed.sv
// rtl/sqrt_fixed.sv - unsigned fixed-point square root, one root bit per cycle
// Optional round-to-nearest root enabled by defining SQRT_FIXED_ROUND_EN.
module sqrt_fixed #(
    parameter int WIDTH = 16,
    parameter int FBITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] rad,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] root,
    output logic [WIDTH-1:0] rem
);
    localparam int ITER = (WIDTH + FBITS) / 2;
    localparam int XW   = 2 * ITER;
    localparam int AW   = ITER + 2;
    localparam int CW   = $clog2(ITER + 1);
`ifdef SQRT_FIXED_ROUND_EN
    localparam int RW   = ITER + 1;
`else
    localparam int RW   = ITER;
`endif
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [ITER-1:0] q_q, q_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   root_q, root_d;
    logic [ITER:0]   rem_q, rem_d;

    logic [AW-1:0]   acc_sh, test, acc_nx;
    logic [ITER-1:0] q_nx;

    // One restoring step; the partial remainder never needs more than AW bits.
    always_comb begin
        acc_sh = AW'({acc_q, x_q[XW-1 -: 2]});
        test   = acc_sh - {q_q, 2'b01};
        if (!test[AW-1]) begin
            acc_nx = test;
            q_nx   = {q_q[ITER-2:0], 1'b1};
        end else begin
            acc_nx = acc_sh;
            q_nx   = {q_q[ITER-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        root_d  = root_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    x_d   = XW'(rad) << FBITS;
                    acc_d = '0;
                    q_d   = '0;
                    cnt_d = '0;
                    if (rad == '0) begin
                        state_d = DONE;
                        root_d  = '0;
                        rem_d   = '0;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                x_d   = x_q << 2;
                acc_d = acc_nx;
                q_d   = q_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    rem_d   = acc_nx[ITER:0];
`ifdef SQRT_FIXED_ROUND_EN
                    // Remainder above the root means the true root is past the half point.
                    if (acc_nx[ITER:0] > {1'b0, q_nx})
                        root_d = RW'(q_nx) + RW'(1);
                    else
                        root_d = RW'(q_nx);
`else
                    root_d = q_nx;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            root_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
        end
    end

    assign busy  = (state_q == CALC);
    assign valid = (state_q == DONE);
    assign root  = WIDTH'(root_q);
    assign rem   = WIDTH'(rem_q);

endmodule

// File: tb/tb_sqrt_fixed.sv
// tb/tb_sqrt_fixed.sv - randomized self-checking bench for sqrt_fixed
// Expected rounding results follow SQRT_FIXED_ROUND_EN when it is defined.
module tb_sqrt_fixed;
    localparam int W    = 16;
    localparam int F    = 8;
    localparam int ITER = (W + F) / 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start = 1'b0;
    logic [W-1:0] rad = '0;
    logic         busy, valid;
    logic [W-1:0] root, rem;

    int n_checks = 0;
    int n_errors = 0;

    sqrt_fixed #(.WIDTH(W), .FBITS(F)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rad(rad),
        .busy(busy), .valid(valid), .root(root), .rem(rem)
    );

    always #5 clk = ~clk;

    function automatic longint ext_of(input logic [W-1:0] r);
        return longint'(r) << F;
    endfunction

    function automatic longint trunc_root(input logic [W-1:0] r);
        longint n, s, t;
        n = ext_of(r);
        s = 0;
        for (int b = ITER; b >= 0; b--) begin
            t = s + (longint'(1) << b);
            if (t * t <= n) s = t;
        end
        return s;
    endfunction

    function automatic logic [W-1:0] ref_rem(input logic [W-1:0] r);
        longint s;
        s = trunc_root(r);
        return W'(ext_of(r) - s * s);
    endfunction

    function automatic logic [W-1:0] ref_root(input logic [W-1:0] r);
        longint s;
        s = trunc_root(r);
`ifdef SQRT_FIXED_ROUND_EN
        if (ext_of(r) - s * s > s) s = s + 1;
`endif
        return W'(s);
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle model: busy for ITER edges after an accept, result lands on the last one.
    int           m_cnt   = 0;
    bit           m_valid = 1'b0;
    bit           m_fresh = 1'b1;
    logic [W-1:0] m_root  = '0, m_rem = '0, p_root = '0, p_rem = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_valid <= 1'b0; m_fresh <= 1'b1;
            m_root <= '0; m_rem <= '0;
        end else if (m_cnt == 0 && start) begin
            if (rad == '0) begin
                m_valid <= 1'b1; m_fresh <= 1'b0; m_root <= '0; m_rem <= '0;
            end else begin
                m_cnt <= ITER; m_valid <= 1'b0;
                p_root <= ref_root(rad); p_rem <= ref_rem(rad);
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_valid <= 1'b1; m_fresh <= 1'b0; m_root <= p_root; m_rem <= p_rem;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", W'(busy), W'(m_cnt > 0));
        chk("valid", W'(valid), W'(m_valid));
        if (m_valid || m_fresh) begin
            chk("root", root, m_root);
            chk("rem", rem, m_rem);
        end
    end

    task automatic wait_valid(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < ITER + 8; i++) begin
            @(negedge clk);
            if (valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL %s: valid timeout got 0 expected 1", name);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] r,
                          input logic [W-1:0] er, input logic [W-1:0] em);
        @(negedge clk); start = 1'b1; rad = r;
        @(negedge clk); start = 1'b0;
        wait_valid(name);
        chk({name, "_root"}, root, er);
        chk({name, "_rem"}, rem, em);
    endtask

    initial begin
        logic [W-1:0] r;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        chk("pin_model_2", ref_rem(16'h0200), 16'd28);
        chk("pin_model_ff", ref_rem(16'hFFFF), 16'd7935);

        run_op("two", 16'h0200, 16'h016A, 16'd28);
        run_op("sixteen", 16'h1000, 16'h0400, 16'd0);
        run_op("one", 16'h0100, 16'h0100, 16'd0);
`ifdef SQRT_FIXED_ROUND_EN
        run_op("allones", 16'hFFFF, 16'h1000, 16'd7935);
`else
        run_op("allones", 16'hFFFF, 16'h0FFF, 16'd7935);
`endif
        run_op("zero", 16'h0000, 16'h0000, 16'd0);
        run_op("four", 16'h0400, 16'h0200, 16'd0);

        // Start pulsed mid-calculation must be ignored.
        @(negedge clk); start = 1'b1; rad = 16'h0900;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; rad = 16'h0200;
        @(negedge clk); start = 1'b0;
        wait_valid("ignore");
        chk("ignore_root", root, 16'h0300);

        // Start held across DONE starts a second operation.
        @(negedge clk); start = 1'b1; rad = 16'h1000;
        @(negedge clk); rad = 16'h0200;
        wait_valid("held1");
        chk("held1_root", root, 16'h0400);
        @(negedge clk); start = 1'b0;
        chk("held_valid_drop", W'(valid), W'(0));
        wait_valid("held2");
        chk("held2_root", root, 16'h016A);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk); start = 1'b1; rad = 16'hFFFF;
        @(negedge clk); start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_valid", W'(valid), W'(0));
        chk("rst_root", root, 16'h0000);
        chk("rst_rem", rem, 16'h0000);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        run_op("after_rst", 16'h0200, 16'h016A, 16'd28);

        for (int i = 0; i < 150; i++) begin
            r = W'($urandom);
            if (i % 10 == 0) r = '0;
            if (i % 17 == 3) r = '1;
            @(negedge clk); start = 1'b1; rad = r;
            @(negedge clk); start = 1'b0;
            if (r != '0 && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, ITER - 3)) @(negedge clk);
                start = 1'b1; rad = W'($urandom);
                @(negedge clk); start = 1'b0;
            end
            wait_valid("rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
